// File: rtl/north_bridge_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : north_bridge_dispatcher
// Description : Reads length-prefixed packets from a non-show-ahead FIFO and
//               forwards each payload word to one of three devices (CPU,
//               MMEM, VGA) over a valid/ready handshake. A packet addressed to
//               destination 3, or one whose device stalls a word for TIMEOUT
//               cycles, is drained from the FIFO and counted as dropped.
//
// Ports       : clk          - clock, all state on the rising edge
//               rst_n        - asynchronous active-low reset
//               fifo_q       - FIFO read data, valid the cycle after rdreq
//               fifo_empty   - FIFO holds no words
//               rdreq        - FIFO read strobe, one cycle per word
//               dev_ready    - per-device accept (0 CPU, 1 MMEM, 2 VGA)
//               dev_valid    - one-hot word-valid to the destination device
//               selector_out - destination index of the packet in flight
//               data_out     - payload word presented to the device
//               busy         - high whenever the FSM is not in IDLE
//               pkt_done     - one-cycle pulse per completed packet
//               drop_count   - saturating count of dropped packets
//
// Revision    : 1.0 - initial release
// ============================================================================
module north_bridge_dispatcher #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] fifo_q,
   input  logic        fifo_empty,
   output logic        rdreq,
   input  logic [2:0]  dev_ready,
   output logic [2:0]  dev_valid,
   output logic [1:0]  selector_out,
   output logic [15:0] data_out,
   output logic        busy,
   output logic        pkt_done,
   output logic [7:0]  drop_count
);

   // Last timer value before a stalled word is abandoned: the word is shown
   // for exactly TIMEOUT cycles, the counter running 0 .. TIMEOUT-1.
   localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [1:0] c_DEST_DROP = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_HDR        = 3'd1,
      S_PLD_RD     = 3'd2,
      S_PLD_WAIT   = 3'd3,
      S_PLD_SEND   = 3'd4,
      S_DRAIN_RD   = 3'd5,
      S_DRAIN_WAIT = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic        armed_q;
   logic [1:0]  sel_q, sel_d;
   logic [3:0]  rem_q, rem_d;
   logic [7:0]  tmr_q, tmr_d;
   logic [15:0] data_q, data_d;
   logic        done_q, done_d;
   logic [7:0]  drop_q, drop_d;

   logic        w_drop_evt;
   logic        w_sel_ready;
   logic [1:0]  w_hdr_dest;
   logic [3:0]  w_hdr_len;
   logic        w_unused_hdr;

   assign w_hdr_dest   = fifo_q[15:14];
   assign w_hdr_len    = fifo_q[3:0];
   assign w_unused_hdr = ^fifo_q[13:4];

   // Only the ready bit of the device owning the current packet matters.
   always_comb begin
      w_sel_ready = 1'b0;
      case (sel_q)
         2'd0:    w_sel_ready = dev_ready[0];
         2'd1:    w_sel_ready = dev_ready[1];
         2'd2:    w_sel_ready = dev_ready[2];
         default: w_sel_ready = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rem_d      = rem_q;
      tmr_d      = tmr_q;
      data_d     = data_q;
      done_d     = 1'b0;
      w_drop_evt = 1'b0;
      rdreq      = 1'b0;
      dev_valid  = 3'b000;

      case (state_q)
         S_IDLE: begin
            // armed_q keeps rdreq low until the first edge after reset release
            if (armed_q && !fifo_empty) begin
               rdreq   = 1'b1;
               state_d = S_HDR;
            end
         end

         S_HDR: begin
            sel_d = w_hdr_dest;
            rem_d = w_hdr_len;
            if (w_hdr_dest == c_DEST_DROP) begin
               w_drop_evt = 1'b1;
               if (w_hdr_len == 4'd0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DRAIN_RD;
               end
            end else if (w_hdr_len == 4'd0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_PLD_RD;
            end
         end

         S_PLD_RD: begin
            if (!fifo_empty) begin
               rdreq   = 1'b1;
               state_d = S_PLD_WAIT;
            end
         end

         S_PLD_WAIT: begin
            data_d  = fifo_q;
            tmr_d   = 8'd0;
            state_d = S_PLD_SEND;
         end

         S_PLD_SEND: begin
            dev_valid = 3'b001 << sel_q;
            if (w_sel_ready) begin
               rem_d = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_PLD_RD;
               end
            end else if (tmr_q == c_TMO_LAST) begin
               // Abandon this word and flush whatever is left of the packet.
               w_drop_evt = 1'b1;
               rem_d      = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DRAIN_RD;
               end
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end

         S_DRAIN_RD: begin
            if (!fifo_empty) begin
               rdreq   = 1'b1;
               state_d = S_DRAIN_WAIT;
            end
         end

         S_DRAIN_WAIT: begin
            rem_d = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAIN_RD;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Saturating drop counter.
   always_comb begin
      drop_d = drop_q;
      if (w_drop_evt && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         armed_q <= 1'b0;
         sel_q   <= 2'd0;
         rem_q   <= 4'd0;
         tmr_q   <= 8'd0;
         data_q  <= 16'd0;
         done_q  <= 1'b0;
         drop_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         sel_q   <= sel_d;
         rem_q   <= rem_d;
         tmr_q   <= tmr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign selector_out = sel_q;
   assign data_out     = data_q;
   assign pkt_done     = done_q;
   assign drop_count   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_north_bridge_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_north_bridge_dispatcher
// Description : Scoreboard bench for north_bridge_dispatcher. Packets are
//               pushed into a FIFO model while a packet-level reference model
//               queues the expected device transfers and completion records;
//               a monitor pops and compares them as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_north_bridge_dispatcher;

   localparam int TMO = 4;

   typedef struct packed {
      logic [1:0]  dest;
      logic [15:0] data;
   } xfer_t;

   typedef struct packed {
      logic [7:0] drop;
      logic [1:0] sel;
      logic [4:0] nx;
      logic       to;
   } done_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] fifo_q;
   logic        fifo_empty;
   logic        rdreq;
   logic [2:0]  dev_ready;
   logic [2:0]  dev_valid;
   logic [1:0]  selector_out;
   logic [15:0] data_out;
   logic        busy;
   logic        pkt_done;
   logic [7:0]  drop_count;

   logic [15:0] fifo[$];
   logic [15:0] pay[$];
   xfer_t       exp_xfer[$];
   done_t       exp_done[$];
   bit          fifo_pend;
   bit          stall_en;
   logic [3:0]  alive;
   int          total_drops;
   int          n_vec;
   int          n_err;

   north_bridge_dispatcher #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_q       (fifo_q),
      .fifo_empty   (fifo_empty),
      .rdreq        (rdreq),
      .dev_ready    (dev_ready),
      .dev_valid    (dev_valid),
      .selector_out (selector_out),
      .data_out     (data_out),
      .busy         (busy),
      .pkt_done     (pkt_done),
      .drop_count   (drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference model: a packet's fate depends only on its destination, its
   // length and whether that device is alive (responds within TIMEOUT).
   task automatic push_pkt(input logic [15:0] hdr);
      logic [1:0]  dest;
      int          n;
      logic [15:0] w;
      xfer_t       x;
      done_t       d;
      dest = hdr[15:14];
      n    = int'(hdr[3:0]);
      fifo.push_back(hdr);
      d.to  = 1'b0;
      d.nx  = 5'd0;
      d.sel = dest;
      for (int i = 0; i < n; i++) begin
         if (pay.size() > 0) w = pay.pop_front();
         else w = 16'($urandom);
         fifo.push_back(w);
         if (dest != 2'd3 && alive[dest]) begin
            x.dest = dest;
            x.data = w;
            exp_xfer.push_back(x);
         end
      end
      if (dest == 2'd3) begin
         total_drops++;
      end else if (n != 0 && alive[dest]) begin
         d.nx = 5'(n);
      end else if (n != 0) begin
         total_drops++;
         d.to = 1'b1;
      end
      d.drop = (total_drops > 255) ? 8'd255 : 8'(total_drops);
      exp_done.push_back(d);
      pay.delete();
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while ((fifo.size() != 0 || fifo_pend || exp_done.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 20000) begin
         fail_now("batch_timeout");
         fifo.delete();
         exp_done.delete();
         exp_xfer.delete();
      end
      repeat (3) @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("xfer_queue_drained", 64'(exp_xfer.size()), 64'd0);
   endtask

   // FIFO model: non-show-ahead, data appears the cycle after rdreq.
   initial begin : fifo_model
      logic [15:0] pend;
      int          stall_cnt;
      fifo_q     = 16'd0;
      fifo_empty = 1'b1;
      fifo_pend  = 1'b0;
      stall_cnt  = 0;
      pend       = 16'd0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) fifo_pend = 1'b0;
         if (fifo_pend) begin
            fifo_q    = pend;
            fifo_pend = 1'b0;
         end
         if (stall_cnt > 0) stall_cnt--;
         else if (stall_en && $urandom_range(0, 15) == 0) stall_cnt = $urandom_range(1, 10);
         fifo_empty = (stall_cnt != 0) || (fifo.size() == 0);
         #1;
         if (rdreq && rst_n) begin
            if (fifo.size() > 0) pend = fifo.pop_front();
            else pend = 16'hDEAD;
            fifo_pend = 1'b1;
         end
      end
   end

   // Device responder: alive devices stall at most two cycles in a row.
   initial begin : responder
      int         stall[3];
      logic [2:0] nr;
      dev_ready = 3'b000;
      for (int d = 0; d < 3; d++) stall[d] = 0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (dev_valid[d] && !dev_ready[d]) stall[d]++;
            else stall[d] = 0;
         end
         @(posedge clk);
         #1;
         for (int d = 0; d < 3; d++) begin
            if (alive[d]) nr[d] = (stall[d] >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            else nr[d] = 1'b0;
         end
         dev_ready = nr;
      end
   end

   initial begin : monitor
      int    run;
      int    maxrun;
      int    nx;
      int    idx;
      bit    prev_rd;
      bit    to_ok;
      xfer_t x;
      done_t d;
      run = 0; maxrun = 0; nx = 0; prev_rd = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run = 0; maxrun = 0; nx = 0; prev_rd = 1'b0;
            continue;
         end
         if (rdreq) begin
            check("rdreq_while_empty", 64'(fifo_empty), 64'd0);
            check("rdreq_back_to_back", 64'(prev_rd), 64'd0);
         end
         prev_rd = rdreq;
         if (dev_valid != 3'b000) begin
            check("dev_valid_onehot", 64'($onehot(dev_valid)), 64'd1);
            idx = 0;
            for (int i = 0; i < 3; i++) if (dev_valid[i]) idx = i;
            if (dev_ready[idx]) begin
               if (exp_xfer.size() == 0) begin
                  fail_now("unexpected_transfer");
               end else begin
                  x = exp_xfer.pop_front();
                  check("transfer", 64'({2'(idx), selector_out, data_out}),
                        64'({x.dest, x.dest, x.data}));
               end
               nx++;
               run = 0;
            end else begin
               run++;
               if (run > maxrun) maxrun = run;
            end
         end else begin
            run = 0;
         end
         if (pkt_done) begin
            if (exp_done.size() == 0) begin
               fail_now("unexpected_pkt_done");
            end else begin
               d     = exp_done.pop_front();
               to_ok = d.to ? (maxrun == TMO) : (maxrun < TMO);
               check("pkt_done", 64'({drop_count, selector_out, 5'(nx), to_ok, busy}),
                     64'({d.drop, d.sel, d.nx, 1'b1, 1'b0}));
            end
            nx = 0; maxrun = 0; run = 0;
         end
      end
   end

   initial begin : driver
      int cyc;
      n_vec       = 0;
      n_err       = 0;
      total_drops = 0;
      rst_n       = 1'b0;
      stall_en    = 1'b0;
      alive       = 4'b0101;

      // Directed packets: VGA delivery, dest-3 drop, MMEM timeout, empty CPU.
      pay.push_back(16'h1234);
      pay.push_back(16'h5678);
      push_pkt(16'h8002);
      push_pkt(16'hC003);
      push_pkt(16'h4001);
      push_pkt(16'h0000);

      repeat (3) @(negedge clk);
      check("reset_outputs",
            64'({rdreq, dev_valid, selector_out, data_out, busy, pkt_done, drop_count}), 64'd0);
      rst_n    = 1'b1;
      stall_en = 1'b1;
      wait_idle();

      for (int b = 0; b < 8; b++) begin
         alive = {1'b0, 3'($urandom)};
         for (int p = 0; p < 12; p++) begin
            push_pkt({2'($urandom_range(0, 3)), 10'($urandom), 4'($urandom_range(0, 15))});
         end
         wait_idle();
      end

      // Enough dest-3 drops to push the counter into saturation.
      for (int p = 0; p < 260; p++) push_pkt({2'b11, 10'($urandom), 4'd0});
      wait_idle();
      check("drop_saturated", 64'(drop_count),
            64'((total_drops > 255) ? 8'd255 : 8'(total_drops)));

      // Asynchronous reset while a word is being offered.
      stall_en = 1'b0;
      alive    = 4'b0000;
      fifo.push_back(16'h4003);
      fifo.push_back(16'hAAAA);
      fifo.push_back(16'hBBBB);
      fifo.push_back(16'hCCCC);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (dev_valid == 3'b000 && cyc < 200);
      if (cyc >= 200) fail_now("send_not_reached");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            64'({rdreq, dev_valid, selector_out, data_out, busy, pkt_done, drop_count}), 64'd0);
      fifo.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("after_reset_idle", 64'({busy, pkt_done, drop_count}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
